comparador_pagamento: RTL and testbench
=======================================

// Module: comparador_pagamento
// PURPOSE
// - Payment responder for the main vending controller. While the controller sits in
//   COMPARADOR (estados == 2'b10), it latches the product price, accumulates coins,
//   and returns a one-cycle OK that sends the controller back to ESPERA.
// - Also drives the dispense pulse and change/refund value to the output mechanism.
// PARAMETERS
// - W        8     width of price, coin value, credit and change
// - TIMEOUT  1000  clock cycles in ACUMULA with no accepted coin before auto-refund (>= 2)
// PORTS
// - clk              in   1  system clock; all state updates on posedge
// - rst_n            in   1  asynchronous active-low reset
// - estados          in   2  controller state: 00 ESPERA, 01 PRODUTO, 10 COMPARADOR
// - preco            in   W  price of the selected product; valid while estados == 2'b10
// - moeda_valida     in   1  one-cycle coin strobe
// - moeda_valor      in   W  value of the coin; sampled only with moeda_valida
// - cancelar         in   1  user cancel request (level; sampled each clock)
// - OK               out  1  one-cycle pulse to the controller: transaction finished
// - liberar          out  1  one-cycle dispense pulse (paid path only)
// - troco            out  W  change/refund value; held until the next OK pulse
// - troco_valido     out  1  one-cycle pulse, coincident with OK
// - credito          out  W  current accumulated credit
// - moeda_rejeitada  out  1  one-cycle pulse: coin refused because credit would overflow
// BEHAVIOUR
// - Reset (rst_n low, async): state OCIOSO; credito, troco and the timeout counter are 0;
//   OK, liberar, troco_valido and moeda_rejeitada are 0.
// - All outputs are registered; pulse outputs are high only in the cycle the FSM is in
//   PAGO or DEVOLVE, and moeda_rejeitada only in the cycle after a refused coin.
// - FSM states:
//   OCIOSO:   credito = 0. If estados == 10, latch preco into preco_reg and go to ACUMULA.
//   ACUMULA:  soma = credito + moeda_valor, computed W+1 bits wide.
//             - Coin handling: on moeda_valida with soma < 2^W, credito <= soma[W-1:0] and
//               the timeout counter clears. With soma >= 2^W, the coin is refused,
//               moeda_rejeitada pulses next cycle and credito is unchanged.
//             - Exit priority, highest first:
//               (a) estados != 10: controller aborted; go to OCIOSO, clear credito,
//                   no OK pulse.
//               (b) cancelar: go to DEVOLVE. A coin accepted in the same cycle is
//                   included in the refund.
//               (c) credit after this cycle's coin >= preco_reg: go to PAGO.
//               (d) timeout counter == TIMEOUT-1: go to DEVOLVE.
//             - The counter increments each ACUMULA cycle with no accepted coin.
//   PAGO:     One cycle. OK = liberar = troco_valido = 1, troco <= credito - preco_reg,
//             credito <= 0. Go to AGUARDA.
//   DEVOLVE:  One cycle. OK = troco_valido = 1, liberar = 0, troco <= credito,
//             credito <= 0. Go to AGUARDA.
//   AGUARDA:  Wait until estados != 10, then go to OCIOSO. Prevents re-arming in the
//             same transaction. Coins here are refused (moeda_rejeitada pulses).
// - Coins in OCIOSO are refused, with a moeda_rejeitada pulse.
// - Latency: a coin strobe in cycle N that reaches the price gives OK/liberar in N+1.
// - preco_reg == 0: PAGO is reached one cycle after entering ACUMULA, with troco = 0.
// - Exact payment: troco = 0 and troco_valido = 1.
// - Timeout with zero credit: DEVOLVE with troco = 0; OK still returns the controller
//   to ESPERA.
// - Reset asserted mid-transaction: credit is discarded with no OK pulse; the controller
//   reset owns recovery.
// TESTING
// - preco=150, coins 100,50 on consecutive cycles -> OK=liberar=troco_valido=1 one cycle
//   after the 50-coin strobe, troco=0, credito=0.
// - preco=120, coins 100,50 -> PAGO, troco=30, troco held until next OK.
// - preco=200, coin 100, then cancelar with a simultaneous coin of 25 -> DEVOLVE,
//   troco=125, liberar=0.
// - TIMEOUT=16, preco=80, coin 50, then idle 16 cycles -> DEVOLVE on the 16th idle
//   cycle, troco=50.
// - credito=250, coin 10 (W=8) -> moeda_rejeitada pulse, credito stays 250. Separately:
//   estados forced to 00 during ACUMULA -> OCIOSO, credito=0, no OK.
// - rst_n low mid-ACUMULA with credito=70 -> all outputs 0 immediately (async). Also: with
//   estados held at 10 after OK, the block stays in AGUARDA and issues no second OK.

Source files
------------

// File: rtl/comparador_pagamento_if.sv
// Bus between the vending controller and the payment responder.
// The controller side drives state, price and coin/cancel inputs; the responder returns OK, change and credit.
interface comparador_pagamento_if #(
    parameter int W = 8
);
    logic [1:0]   estados;
    logic [W-1:0] preco;
    logic         moeda_valida;
    logic [W-1:0] moeda_valor;
    logic         cancelar;
    logic         OK;
    logic         liberar;
    logic [W-1:0] troco;
    logic         troco_valido;
    logic [W-1:0] credito;
    logic         moeda_rejeitada;

    modport master (
        output estados, preco, moeda_valida, moeda_valor, cancelar,
        input  OK, liberar, troco, troco_valido, credito, moeda_rejeitada
    );

    modport slave (
        input  estados, preco, moeda_valida, moeda_valor, cancelar,
        output OK, liberar, troco, troco_valido, credito, moeda_rejeitada
    );
endinterface

// File: rtl/comparador_pagamento.sv
// Payment responder: latches the price while the controller is in COMPARADOR, accumulates
// coins and finishes with a one-cycle OK, either paying out (with change) or refunding.
module comparador_pagamento #(
    parameter int W       = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    comparador_pagamento_if.slave   bus
);
    typedef enum logic [2:0] {OCIOSO, ACUMULA, PAGO, DEVOLVE, AGUARDA} state_t;

    localparam logic [1:0] COMPARADOR = 2'b10;
    localparam int         CW         = $clog2(TIMEOUT);

    state_t         state, state_nx;
    logic [W-1:0]   preco_reg;
    logic [W-1:0]   credito_q, credito_nx;
    logic [W-1:0]   troco_q;
    logic [CW-1:0]  cnt;
    logic [W:0]     soma;
    logic           aceita;
    logic           em_comparador;
    logic           ok_q, liberar_q, troco_valido_q, rejeitada_q;

    assign em_comparador = (bus.estados == COMPARADOR);

    // NOTE: every variable gets its default before the case, so no path can infer a latch.
    always_comb begin
        state_nx   = state;
        soma       = {1'b0, credito_q} + {1'b0, bus.moeda_valor};
        aceita     = 1'b0;
        credito_nx = credito_q;
        case (state)
            OCIOSO: begin
                if (em_comparador) state_nx = ACUMULA;
            end
            ACUMULA: begin
                // Overflow shows up in the carry bit; such a coin is refused and credit holds.
                aceita = bus.moeda_valida && !soma[W];
                if (aceita) credito_nx = soma[W-1:0];
                if (!em_comparador)                               state_nx = OCIOSO;
                else if (bus.cancelar)                            state_nx = DEVOLVE;
                else if (credito_nx >= preco_reg)                 state_nx = PAGO;
                else if (!aceita && cnt == CW'(TIMEOUT - 1))      state_nx = DEVOLVE;
            end
            PAGO, DEVOLVE: state_nx = AGUARDA;
            AGUARDA: begin
                if (!em_comparador) state_nx = OCIOSO;
            end
            default: state_nx = OCIOSO;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= OCIOSO;
            preco_reg      <= '0;
            credito_q      <= '0;
            troco_q        <= '0;
            cnt            <= '0;
            ok_q           <= 1'b0;
            liberar_q      <= 1'b0;
            troco_valido_q <= 1'b0;
            rejeitada_q    <= 1'b0;
        end else begin
            state          <= state_nx;
            ok_q           <= (state_nx == PAGO) || (state_nx == DEVOLVE);
            troco_valido_q <= (state_nx == PAGO) || (state_nx == DEVOLVE);
            liberar_q      <= (state_nx == PAGO);
            rejeitada_q    <= bus.moeda_valida && !aceita;

            if (state == OCIOSO) begin
                cnt <= '0;
                if (em_comparador) preco_reg <= bus.preco;
            end else if (state == ACUMULA) begin
                cnt <= aceita ? '0 : cnt + 1'b1;
            end

            // Change is loaded on the way into the pulse cycle so it is valid alongside troco_valido.
            if (state_nx == PAGO)         troco_q <= credito_nx - preco_reg;
            else if (state_nx == DEVOLVE) troco_q <= credito_nx;

            credito_q <= (state_nx == ACUMULA) ? credito_nx : '0;
        end
    end

    assign bus.OK              = ok_q;
    assign bus.liberar         = liberar_q;
    assign bus.troco_valido    = troco_valido_q;
    assign bus.moeda_rejeitada = rejeitada_q;
    assign bus.troco           = troco_q;
    assign bus.credito         = credito_q;
endmodule

// File: tb/tb_comparador_pagamento.sv
// Bench for comparador_pagamento: directed scenarios with literal expectations, then randomized
// traffic, all checked every cycle against a transaction-level payment model.
module tb_comparador_pagamento;
    localparam int W       = 8;
    localparam int TIMEOUT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    comparador_pagamento_if #(.W(W)) bus();

    comparador_pagamento #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Payment model: a transaction is "open" while collecting coins, then a one-cycle
    // finish pulse, then a hold period until the controller leaves COMPARADOR.
    bit m_open, m_pulse, m_hold;
    int m_credit, m_price, m_idle;
    bit e_ok, e_lib, e_rej;
    int e_troco, e_cred;

    always @(posedge clk or negedge rst_n) begin : model
        bit open, pulse, hold, ok, lib, rej, acc, done, paid, coin, armed;
        int credit, price, idle, troco;
        if (!rst_n) begin
            m_open <= 0; m_pulse <= 0; m_hold <= 0;
            m_credit <= 0; m_price <= 0; m_idle <= 0;
            e_ok <= 0; e_lib <= 0; e_rej <= 0; e_troco <= 0; e_cred <= 0;
        end else begin
            open = m_open; pulse = m_pulse; hold = m_hold;
            credit = m_credit; price = m_price; idle = m_idle; troco = e_troco;
            ok = 0; lib = 0; acc = 0; done = 0; paid = 0;
            coin  = bus.moeda_valida;
            armed = (bus.estados == 2'b10);
            rej   = coin;
            if (pulse) begin
                pulse = 0;
                hold  = 1;
            end else if (hold) begin
                if (!armed) hold = 0;
            end else if (!open) begin
                credit = 0;
                if (armed) begin
                    open  = 1;
                    price = int'(bus.preco);
                    idle  = 0;
                end
            end else begin
                acc = coin && (credit + int'(bus.moeda_valor) < 256);
                rej = coin && !acc;
                if (acc) credit = credit + int'(bus.moeda_valor);
                if (!armed) begin
                    open = 0;
                    credit = 0;
                end else if (bus.cancelar) done = 1;
                else if (credit >= price) begin
                    done = 1;
                    paid = 1;
                end else if (!acc && idle == TIMEOUT - 1) done = 1;
                else idle = acc ? 0 : idle + 1;
                if (done) begin
                    ok     = 1;
                    lib    = paid;
                    troco  = paid ? credit - price : credit;
                    credit = 0;
                    open   = 0;
                    pulse  = 1;
                end
            end
            m_open <= open; m_pulse <= pulse; m_hold <= hold;
            m_credit <= credit; m_price <= price; m_idle <= idle;
            e_ok <= ok; e_lib <= lib; e_rej <= rej; e_troco <= troco; e_cred <= credit;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ok",           bus.OK,              e_ok);
            check("liberar",      bus.liberar,         e_lib);
            check("troco_valido", bus.troco_valido,    e_ok);
            check("rejeitada",    bus.moeda_rejeitada, e_rej);
            check("troco",        bus.troco,           e_troco);
            check("credito",      bus.credito,         e_cred);
        end
    end

    task automatic idle_bus();
        bus.estados      = 2'b00;
        bus.moeda_valida = 1'b0;
        bus.cancelar     = 1'b0;
    endtask

    task automatic start_txn(input logic [W-1:0] price);
        bus.estados = 2'b10;
        bus.preco   = price;
        @(negedge clk);
    endtask

    task automatic coin(input logic [W-1:0] v);
        bus.moeda_valida = 1'b1;
        bus.moeda_valor  = v;
        @(negedge clk);
        bus.moeda_valida = 1'b0;
    endtask

    task automatic end_txn();
        idle_bus();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;
        int oks;
        int coin_pct;
        idle_bus();
        bus.preco       = '0;
        bus.moeda_valor = '0;
        repeat (2) @(negedge clk);
        check("rst_ok",      bus.OK,      0);
        check("rst_credito", bus.credito, 0);
        check("rst_troco",   bus.troco,   0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // Exact payment
        start_txn(8'd150); coin(8'd100); coin(8'd50);
        check("exact_ok",      bus.OK,           1);
        check("exact_liberar", bus.liberar,      1);
        check("exact_tv",      bus.troco_valido, 1);
        check("exact_troco",   bus.troco,        0);
        check("exact_credito", bus.credito,      0);
        end_txn();

        // Overpayment, change held afterwards
        start_txn(8'd120); coin(8'd100); coin(8'd50);
        check("change_troco",   bus.troco,   30);
        check("change_liberar", bus.liberar, 1);
        end_txn();
        repeat (3) @(negedge clk);
        check("change_held", bus.troco,        30);
        check("change_tv0",  bus.troco_valido, 0);

        // Cancel with a coin in the same cycle
        start_txn(8'd200); coin(8'd100);
        bus.cancelar = 1'b1;
        coin(8'd25);
        bus.cancelar = 1'b0;
        check("cancel_ok",      bus.OK,      1);
        check("cancel_liberar", bus.liberar, 0);
        check("cancel_troco",   bus.troco,   125);
        end_txn();

        // Timeout refund
        start_txn(8'd80); coin(8'd50);
        seen = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.OK === 1'b1) begin
                seen = i;
                break;
            end
        end
        check("timeout_cycles",  seen,        16);
        check("timeout_troco",   bus.troco,   50);
        check("timeout_liberar", bus.liberar, 0);
        end_txn();

        // Overflowing coin, then controller abort
        start_txn(8'd255); coin(8'd250); coin(8'd10);
        check("ovf_rej",     bus.moeda_rejeitada, 1);
        check("ovf_credito", bus.credito,         250);
        bus.estados = 2'b00;
        @(negedge clk);
        check("abort_credito", bus.credito, 0);
        check("abort_ok",      bus.OK,      0);
        @(negedge clk);

        // Zero price, then hold in COMPARADOR without a second OK
        start_txn(8'd0);
        @(negedge clk);
        check("zero_ok",      bus.OK,      1);
        check("zero_liberar", bus.liberar, 1);
        check("zero_troco",   bus.troco,   0);
        @(negedge clk);
        coin(8'd5);
        check("hold_rej", bus.moeda_rejeitada, 1);
        oks = 0;
        repeat (5) begin
            @(negedge clk);
            oks += int'(bus.OK);
        end
        check("hold_no_ok", oks, 0);
        end_txn();

        // Asynchronous reset mid-transaction
        start_txn(8'd200); coin(8'd70);
        check("pre_rst_credito", bus.credito, 70);
        #2 rst_n = 1'b0;
        #1;
        check("arst_credito", bus.credito,         0);
        check("arst_troco",   bus.troco,           0);
        check("arst_ok",      bus.OK,              0);
        check("arst_liberar", bus.liberar,         0);
        check("arst_rej",     bus.moeda_rejeitada, 0);
        idle_bus();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized traffic
        coin_pct = 30;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       coin_pct = 4;
                    1:       coin_pct = 30;
                    default: coin_pct = 70;
                endcase
            end
            if (bus.estados == 2'b10) begin
                if ($urandom_range(0, 99) < 2) bus.estados = 2'b00;
            end else if ($urandom_range(0, 99) < 30) begin
                bus.estados = 2'b10;
            end else begin
                bus.estados = 2'($urandom_range(0, 1));
            end
            bus.preco        = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 255))
                                                           : W'($urandom_range(0, 160));
            bus.moeda_valida = ($urandom_range(0, 99) < coin_pct);
            bus.moeda_valor  = ($urandom_range(0, 9) == 0) ? W'($urandom_range(150, 255))
                                                           : W'($urandom_range(1, 100));
            bus.cancelar     = ($urandom_range(0, 99) < 2);
            @(negedge clk);
        end

        idle_bus();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
